onehot_decoder_seq: RTL and testbench

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

---
 rtl/decoder_pkg.sv | 33 +++
 rtl/step_prescaler.sv | 37 +++
 rtl/onehot_decoder_seq.sv | 102 ++++++++++
 tb/tb_onehot_decoder_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the one-hot decoder/scanner: mode codes, FSM states,
// output width derivation and mode-to-state mapping.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DECODE  = 2'b00,
    MODE_SCAN_UP = 2'b01,
    MODE_SCAN_DN = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_SCAN_UP = 3'd2,
    ST_SCAN_DN = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  function automatic int unsigned out_width(input int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

  function automatic state_e mode_to_state(input mode_e m);
    case (m)
      MODE_DECODE:  return ST_DECODE;
      MODE_SCAN_UP: return ST_SCAN_UP;
      MODE_SCAN_DN: return ST_SCAN_DN;
      default:      return ST_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Scan-rate prescaler: counts 0..STEP-1 while run is high and pulses tick
// on the terminal count; clear returns the count to zero.
module step_prescaler #(
  parameter int unsigned STEP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(STEP - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_decoder_seq.sv
// One-hot decoder with scan modes: decodes accepted select codes, or steps a
// retained code up/down at a prescaled rate, driving a registered one-hot bus.
module onehot_decoder_seq
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned STEP  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [1:0]                   mode,
  input  logic [SEL_W-1:0]             sel_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [out_width(SEL_W)-1:0]  dout,
  output logic                         out_valid,
  output logic [SEL_W-1:0]             cur_sel,
  output logic                         wrap
);

  localparam int unsigned OUT_W = out_width(SEL_W);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic               out_valid_q, out_valid_d;
  logic               wrap_q, wrap_d;

  logic in_ready_c;
  logic xfer_c;
  logic stable_c;
  logic run_c;
  logic clear_c;
  logic tick_c;

  // Next state follows mode every cycle; en low always parks in IDLE.
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = mode_to_state(mode_e'(mode));
    end
  end

  assign in_ready_c = (state_q == ST_DECODE) && en && (mode_e'(mode) == MODE_DECODE);
  assign xfer_c     = in_ready_c && in_valid;
  assign stable_c   = (state_d == state_q);
  assign run_c      = stable_c && ((state_q == ST_SCAN_UP) || (state_q == ST_SCAN_DN));
  assign clear_c    = !stable_c || (state_q == ST_IDLE);

  step_prescaler #(
    .STEP (STEP)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear_c),
    .run   (run_c),
    .tick  (tick_c)
  );

  // Datapath: dout is always derived from the code it will represent, so it
  // stays one-hot outside IDLE and is restored on IDLE exit.
  always_comb begin
    cur_sel_d   = cur_sel_q;
    out_valid_d = 1'b0;
    wrap_d      = 1'b0;
    if (xfer_c) begin
      cur_sel_d   = sel_in;
      out_valid_d = 1'b1;
    end else if (tick_c && (state_q == ST_SCAN_UP)) begin
      cur_sel_d = cur_sel_q + SEL_W'(1);
      wrap_d    = (cur_sel_q == {SEL_W{1'b1}});
    end else if (tick_c && (state_q == ST_SCAN_DN)) begin
      cur_sel_d = cur_sel_q - SEL_W'(1);
      wrap_d    = (cur_sel_q == '0);
    end
    dout_d = (state_d == ST_IDLE) ? '0 : (OUT_W'(1) << cur_sel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dout_q      <= '0;
      cur_sel_q   <= '0;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      cur_sel_q   <= cur_sel_d;
      out_valid_q <= out_valid_d;
      wrap_q      <= wrap_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign dout      = dout_q;
  assign cur_sel   = cur_sel_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: STEP=1 and STEP=4 instances on shared inputs,
// a directed vector table, hand sequences and random traffic against a model.
module tb_onehot_decoder_seq;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel_in;
  logic             in_valid;

  logic             rdy1, ov1, wrap1, rdy4, ov4, wrap4;
  logic [OUT_W-1:0] dout1, dout4;
  logic [SEL_W-1:0] cur1, cur4;

  onehot_decoder_seq #(.SEL_W(SEL_W), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .in_valid(in_valid), .in_ready(rdy1), .dout(dout1), .out_valid(ov1),
    .cur_sel(cur1), .wrap(wrap1)
  );

  onehot_decoder_seq #(.SEL_W(SEL_W), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in),
    .in_valid(in_valid), .in_ready(rdy4), .dout(dout4), .out_valid(ov4),
    .cur_sel(cur4), .wrap(wrap4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, index 0 -> STEP=1, index 1 -> STEP=4.
  // m_phase counts scan cycles since entry or the last advance.
  int steps   [2] = '{1, 4};
  int m_state [2];   // 0 = idle, otherwise mode + 1
  int m_sel   [2];
  int m_phase [2];
  int m_dout  [2];
  int m_ov    [2];
  int m_wrap  [2];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 0; m_sel[d] = 0; m_phase[d] = 0;
      m_dout[d] = 0;  m_ov[d] = 0;  m_wrap[d] = 0;
    end
  endtask

  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      int nst;
      bit ready;
      nst = en ? (int'(mode) + 1) : 0;
      ready = (m_state[d] == 1) && (nst == 1);
      m_ov[d] = 0;
      m_wrap[d] = 0;
      if (nst != m_state[d]) begin
        m_phase[d] = 0;
      end else if (m_state[d] == 2 || m_state[d] == 3) begin
        m_phase[d] = m_phase[d] + 1;
        if (m_phase[d] == steps[d]) begin
          m_phase[d] = 0;
          if (m_state[d] == 2) begin
            m_wrap[d] = (m_sel[d] == OUT_W - 1) ? 1 : 0;
            m_sel[d]  = (m_sel[d] + 1) % OUT_W;
          end else begin
            m_wrap[d] = (m_sel[d] == 0) ? 1 : 0;
            m_sel[d]  = (m_sel[d] + OUT_W - 1) % OUT_W;
          end
        end
      end
      if (ready && in_valid) begin
        m_sel[d] = int'(sel_in);
        m_ov[d]  = 1;
      end
      m_dout[d] = (nst == 0) ? 0 : (1 << m_sel[d]);
      m_state[d] = nst;
    end
  endtask

  task automatic check_all();
    chk("dout_s1",  int'(dout1), m_dout[0]);
    chk("cur_s1",   int'(cur1),  m_sel[0]);
    chk("ov_s1",    int'(ov1),   m_ov[0]);
    chk("wrap_s1",  int'(wrap1), m_wrap[0]);
    chk("onehot_s1", int'($onehot0(dout1)), 1);
    chk("dout_s4",  int'(dout4), m_dout[1]);
    chk("cur_s4",   int'(cur4),  m_sel[1]);
    chk("ov_s4",    int'(ov4),   m_ov[1]);
    chk("wrap_s4",  int'(wrap4), m_wrap[1]);
    chk("onehot_s4", int'($onehot0(dout4)), 1);
  endtask

  // Called at posedge+1 with inputs already set; ends at the next posedge+1.
  task automatic step();
    int exp_rdy;
    #1;
    exp_rdy = (m_state[0] == 1 && en && mode == 2'b00) ? 1 : 0;
    chk("ready_s1", int'(rdy1), exp_rdy);
    exp_rdy = (m_state[1] == 1 && en && mode == 2'b00) ? 1 : 0;
    chk("ready_s4", int'(rdy4), exp_rdy);
    model_eval();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dout_s1", int'(dout1), 0);
    chk("rst_cur_s1",  int'(cur1),  0);
    chk("rst_ov_s1",   int'(ov1),   0);
    chk("rst_wrap_s1", int'(wrap1), 0);
    chk("rst_dout_s4", int'(dout4), 0);
    chk("rst_cur_s4",  int'(cur4),  0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [2:0] s, input logic v);
    en = e; mode = m; sel_in = s; in_valid = v;
  endtask

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       valid;
    logic [7:0] exp_dout;
    logic [2:0] exp_cur;
    logic       exp_ov;
    logic       exp_wrap;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 1'b0);
    model_reset();

    // Directed table for the STEP=1 instance.
    tbl.push_back('{1'b1, 2'b00, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0});
    for (int i = 0; i < 8; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << i;
      tbl.push_back('{1'b1, 2'b00, 3'(i), 1'b1, oh, 3'(i), 1'b1, 1'b0});
    end
    tbl.push_back('{1'b1, 2'b00, 3'd2, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b00, 3'd6, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 3'd0, 1'b0, 8'h40, 3'd6, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 3'd3, 1'b1, 8'h80, 3'd7, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b01, 3'd0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 2'b01, 3'd0, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 3'd0, 1'b0, 8'h02, 3'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 3'd4, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b10, 3'd0, 1'b0, 8'h80, 3'd7, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 2'b00, 3'd0, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b00, 3'd5, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 2'b00, 3'd2, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 2'b11, 3'd0, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b11, 3'd0, 1'b0, 8'h20, 3'd5, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 2'b11, 3'd1, 1'b1, 8'h20, 3'd5, 1'b0, 1'b0});

    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].mode, tbl[i].sel, tbl[i].valid);
      step();
      chk($sformatf("tbl%0d_dout", i), int'(dout1), int'(tbl[i].exp_dout));
      chk($sformatf("tbl%0d_cur", i),  int'(cur1),  int'(tbl[i].exp_cur));
      chk($sformatf("tbl%0d_ov", i),   int'(ov1),   int'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_wrap", i), int'(wrap1), int'(tbl[i].exp_wrap));
    end

    // STEP=4 scan cadence, HOLD freeze and restart delay.
    do_reset();
    drive(1'b1, 2'b00, 3'd0, 1'b0);
    step();
    drive(1'b1, 2'b01, 3'd0, 1'b0);
    for (int k = 0; k <= 12; k++) begin
      step();
      chk("s4_scan_cur", int'(cur4), k / 4);
      chk("s4_scan_dout", int'(dout4), 1 << (k / 4));
    end
    drive(1'b1, 2'b11, 3'd0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("s4_hold_cur", int'(cur4), 3);
      chk("s4_hold_dout", int'(dout4), 8);
    end
    drive(1'b1, 2'b01, 3'd0, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      step();
      chk("s4_resume_cur", int'(cur4), 3 + k / 4);
    end

    // Reset in the middle of a STEP=1 scan sitting at code 3.
    do_reset();
    drive(1'b1, 2'b00, 3'd0, 1'b0);
    step();
    drive(1'b1, 2'b00, 3'd2, 1'b1);
    step();
    drive(1'b1, 2'b01, 3'd0, 1'b0);
    step();
    step();
    chk("mid_scan_cur", int'(cur1), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dout", int'(dout1), 0);
    chk("mid_rst_cur",  int'(cur1),  0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 2'b00, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_ov", int'(ov1), 0);
      chk("post_rst_wrap", int'(wrap1), 0);
    end

    // Random traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        drive(($urandom_range(9) != 0) ? 1'b1 : 1'b0,
              2'($urandom_range(3)),
              3'($urandom_range(7)),
              1'($urandom_range(1)));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
